// File: rtl/keypad_move_ctrl_if.sv
// Bundles the keypad matrix pins and the game-core command outputs of keypad_move_ctrl.
// master = the controller; slave = the keypad/game-core side.
interface keypad_move_ctrl_if;
    logic [3:0] kp_col_out;
    logic [3:0] kp_row_in;
    logic [3:0] keypadButton;
    logic       key_held;
    logic [2:0] col;
    logic       pop;
    logic       move_stb;
    logic       reset_req;

    modport master (
        output kp_col_out, keypadButton, key_held, col, pop, move_stb, reset_req,
        input  kp_row_in
    );

    modport slave (
        input  kp_col_out, keypadButton, key_held, col, pop, move_stb, reset_req,
        output kp_row_in
    );
endinterface

// File: rtl/keypad_move_ctrl.sv
// 4x4 keypad scanner, debouncer and Connect-4 command decoder.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (cursor auto-repeat for keys A/B).
module keypad_move_ctrl #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic              myClk,
    input  logic              reset,
    keypad_move_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [4:0] KEY_NONE = 5'h10;

    typedef enum logic [1:0] {PH_C0, PH_C1, PH_C2, PH_C3} phase_t;

    function automatic logic [3:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:  key_code = 4'h1;
            4'd1:  key_code = 4'h4;
            4'd2:  key_code = 4'h7;
            4'd3:  key_code = 4'h0;
            4'd4:  key_code = 4'h2;
            4'd5:  key_code = 4'h5;
            4'd6:  key_code = 4'h8;
            4'd7:  key_code = 4'hF;
            4'd8:  key_code = 4'h3;
            4'd9:  key_code = 4'h6;
            4'd10: key_code = 4'h9;
            4'd11: key_code = 4'hE;
            4'd12: key_code = 4'hA;
            4'd13: key_code = 4'hB;
            4'd14: key_code = 4'hC;
            default: key_code = 4'hD;
        endcase
    endfunction

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       kp_col_q, kp_col_d;
    logic [11:0]      samp_q, samp_d;
    logic [4:0]       prev_raw_q, prev_raw_d;
    logic [3:0]       stab_q, stab_d;
    logic [4:0]       acc_q, acc_d;
    logic             evt_q, evt_d;
    logic [3:0]       evt_key_q, evt_key_d;
    logic [3:0]       btn_q, btn_d;
    logic             held_q, held_d;
    logic [2:0]       col_q, col_d;
    logic             pop_q, pop_d;
    logic             mv_q, mv_d;
    logic             rr_q, rr_d;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    logic        tc;
    logic        scan_done;
    logic [15:0] pressed_now;
    logic [4:0]  n_hot;
    logic [3:0]  hot_idx;
    logic [4:0]  raw;
    phase_t      phase_nx;

    assign tc        = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign scan_done = tc && (phase_q == PH_C3);

    // C3 rows are taken live on its terminal cycle; C0..C2 come from the sample register.
    always_comb begin
        pressed_now = {~bus.kp_row_in, samp_q};
        n_hot   = 5'd0;
        hot_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pressed_now[i]) begin
                n_hot   = n_hot + 5'd1;
                hot_idx = 4'(i);
            end
        end
        raw = (n_hot == 5'd1) ? {1'b0, key_code(hot_idx)} : KEY_NONE;
    end

    always_comb begin
        phase_d    = phase_q;
        cnt_d      = tc ? '0 : cnt_q + CNT_W'(1);
        kp_col_d   = kp_col_q;
        samp_d     = samp_q;
        prev_raw_d = prev_raw_q;
        stab_d     = stab_q;
        acc_d      = acc_q;
        evt_d      = 1'b0;
        evt_key_d  = evt_key_q;
        btn_d      = btn_q;
        col_d      = col_q;
        pop_d      = pop_q;
        mv_d       = 1'b0;
        rr_d       = 1'b0;
        phase_nx   = phase_t'(phase_q + 2'd1);
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d      = rep_q;
`endif

        if (tc) begin
            phase_d  = phase_nx;
            kp_col_d = ~(4'b0001 << phase_nx);
            if (phase_q != PH_C3)
                samp_d[{phase_q, 2'b00} +: 4] = ~bus.kp_row_in;
        end

        if (scan_done) begin
            prev_raw_d = raw;
            if (raw == prev_raw_q)
                stab_d = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
            else
                stab_d = 4'd1;
            if (stab_d >= 4'(DEBOUNCE_SCANS) && raw != acc_q) begin
                acc_d = raw;
                // Only NONE -> key is a press; key -> key swaps are silent.
                if (acc_q == KEY_NONE && !raw[4]) begin
                    evt_d     = 1'b1;
                    evt_key_d = raw[3:0];
                end
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (evt_d || acc_d != acc_q)
                rep_d = '0;
            else if (acc_q == {1'b0, 4'hA} || acc_q == {1'b0, 4'hB}) begin
                if (rep_q == REP_W'(REPEAT_SCANS - 1)) begin
                    rep_d     = '0;
                    evt_d     = 1'b1;
                    evt_key_d = acc_q[3:0];
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end else
                rep_d = '0;
`endif
        end

        held_d = ~acc_d[4];

        if (mv_q)
            pop_d = 1'b0;

        // Actions land one cycle after the scan edge, together with their pulse.
        if (evt_q) begin
            btn_d = evt_key_q;
            case (evt_key_q)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                    col_d = evt_key_q[2:0] - 3'd1;
                    mv_d  = 1'b1;
                end
                4'h0: pop_d = ~pop_q;
                4'hA: if (col_q != 3'd0) col_d = col_q - 3'd1;
                4'hB: if (col_q < 3'd6) col_d = col_q + 3'd1;
                4'hC: mv_d = 1'b1;
                4'hF: begin
                    rr_d  = 1'b1;
                    pop_d = 1'b0;
                    col_d = 3'd3;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge myClk or negedge reset) begin
        if (!reset) begin
            phase_q    <= PH_C0;
            cnt_q      <= '0;
            kp_col_q   <= 4'b1110;
            samp_q     <= '0;
            prev_raw_q <= KEY_NONE;
            stab_q     <= 4'd0;
            acc_q      <= KEY_NONE;
            evt_q      <= 1'b0;
            evt_key_q  <= 4'd0;
            btn_q      <= 4'd0;
            held_q     <= 1'b0;
            col_q      <= 3'd3;
            pop_q      <= 1'b0;
            mv_q       <= 1'b0;
            rr_q       <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            kp_col_q   <= kp_col_d;
            samp_q     <= samp_d;
            prev_raw_q <= prev_raw_d;
            stab_q     <= stab_d;
            acc_q      <= acc_d;
            evt_q      <= evt_d;
            evt_key_q  <= evt_key_d;
            btn_q      <= btn_d;
            held_q     <= held_d;
            col_q      <= col_d;
            pop_q      <= pop_d;
            mv_q       <= mv_d;
            rr_q       <= rr_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign bus.kp_col_out   = kp_col_q;
    assign bus.keypadButton = btn_q;
    assign bus.key_held     = held_q;
    assign bus.col          = col_q;
    assign bus.pop          = pop_q;
    assign bus.move_stb     = mv_q;
    assign bus.reset_req    = rr_q;
endmodule

// File: tb/tb_keypad_move_ctrl.sv
// Directed bench for keypad_move_ctrl: a keypad matrix model plus pulse monitors.
module tb_keypad_move_ctrl;
    localparam int SD   = 4;
    localparam int SCAN = 4 * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] pressed = 16'h0;
    logic [3:0]  rows;

    int n_checks = 0;
    int n_fail   = 0;

    int mv_cnt = 0, rr_cnt = 0, both_cnt = 0;
    logic [2:0] last_col = 3'd0;
    logic       last_pop = 1'b0;
    logic [3:0] last_btn = 4'd0;
    logic [2:0] rr_col = 3'd0;
    logic       rr_pop = 1'b0;
    logic       pop_after = 1'b1;
    logic       prev_mv = 1'b0;

    keypad_move_ctrl_if bus ();

    keypad_move_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(8)) dut (
        .myClk (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!bus.kp_col_out[c]) rows = rows & ~pressed[c*4 +: 4];
    end
    assign bus.kp_row_in = rows;

    always @(negedge clk) begin
        if (bus.move_stb) begin
            mv_cnt++;
            last_col = bus.col;
            last_pop = bus.pop;
            last_btn = bus.keypadButton;
        end
        if (bus.reset_req) begin
            rr_cnt++;
            rr_col = bus.col;
            rr_pop = bus.pop;
        end
        if (bus.move_stb && bus.reset_req) both_cnt++;
        if (prev_mv) pop_after = bus.pop;
        prev_mv = bus.move_stb;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else
            $display("ok   %s: 0x%0h", tag, got);
    endtask

    function automatic int key_idx(input logic [3:0] code);
        case (code)
            4'h1: return 0;   4'h4: return 1;   4'h7: return 2;   4'h0: return 3;
            4'h2: return 4;   4'h5: return 5;   4'h8: return 6;   4'hF: return 7;
            4'h3: return 8;   4'h6: return 9;   4'h9: return 10;  4'hE: return 11;
            4'hA: return 12;  4'hB: return 13;  4'hC: return 14;  default: return 15;
        endcase
    endfunction

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] code, input int hold);
        pressed = 16'h0;
        pressed[key_idx(code)] = 1'b1;
        wait_scans(hold);
        pressed = 16'h0;
        wait_scans(3);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int base_mv, base_rr;
    logic [3:0] exp_col;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_kp_col", bus.kp_col_out, 4'b1110);
        chk("rst_col", bus.col, 3'd3);
        chk("rst_pop", bus.pop, 1'b0);
        chk("rst_btn", bus.keypadButton, 4'h0);
        chk("rst_held", bus.key_held, 1'b0);
        chk("rst_pulses", {bus.move_stb, bus.reset_req}, 2'b00);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << (i / 4));
            chk($sformatf("walk_%0d", i), bus.kp_col_out, exp_col);
            @(negedge clk);
        end

        // Drop with key 5, then hold without repeat
        base_mv = mv_cnt;
        pressed = 16'h0;
        pressed[key_idx(4'h5)] = 1'b1;
        wait_scans(3);
        chk("drop_count", mv_cnt - base_mv, 1);
        chk("drop_col", last_col, 3'd4);
        chk("drop_pop", last_pop, 1'b0);
        chk("drop_btn", last_btn, 4'h5);
        chk("drop_held", bus.key_held, 1'b1);
        wait_scans(10);
        pressed = 16'h0;
        wait_scans(3);
        chk("drop_no_repeat", mv_cnt - base_mv, 1);
        chk("drop_released", bus.key_held, 1'b0);

        // Pop mode
        press_key(4'h0, 3);
        chk("pop_armed", bus.pop, 1'b1);
        base_mv = mv_cnt;
        press_key(4'h2, 3);
        chk("pop_count", mv_cnt - base_mv, 1);
        chk("pop_during", last_pop, 1'b1);
        chk("pop_col", last_col, 3'd1);
        chk("pop_after", pop_after, 1'b0);

        // Cursor
        reset_dut();
        press_key(4'hB, 3); chk("cur_b1", bus.col, 3'd4);
        press_key(4'hB, 3); chk("cur_b2", bus.col, 3'd5);
        press_key(4'hB, 3); chk("cur_b3", bus.col, 3'd6);
        press_key(4'hB, 3); chk("cur_b4", bus.col, 3'd6);
        for (int i = 0; i < 7; i++) press_key(4'hA, 3);
        chk("cur_a_sat", bus.col, 3'd0);
        base_mv = mv_cnt;
        press_key(4'hC, 3);
        chk("cur_c_count", mv_cnt - base_mv, 1);
        chk("cur_c_col", last_col, 3'd0);
        chk("cur_c_btn", bus.keypadButton, 4'hC);

        // Bouncing key 7
        base_mv = mv_cnt;
        for (int i = 0; i < 12; i++) begin
            pressed = (i % 2 == 0) ? 16'h0004 : 16'h0000;
            wait_scans(1);
        end
        pressed = 16'h0;
        wait_scans(3);
        chk("bounce_no_evt", mv_cnt - base_mv, 0);
        chk("bounce_btn", bus.keypadButton, 4'hC);

        // Ghost: keys 1 and 2 together
        base_mv = mv_cnt;
        pressed = 16'h0;
        pressed[key_idx(4'h1)] = 1'b1;
        pressed[key_idx(4'h2)] = 1'b1;
        wait_scans(5);
        chk("ghost_held", bus.key_held, 1'b0);
        pressed = 16'h0;
        wait_scans(3);
        chk("ghost_no_evt", mv_cnt - base_mv, 0);
        chk("ghost_btn", bus.keypadButton, 4'hC);

        // Game reset request
        press_key(4'h0, 3);
        press_key(4'hB, 3);
        chk("gr_pre_pop", bus.pop, 1'b1);
        chk("gr_pre_col", bus.col, 3'd1);
        base_mv = mv_cnt;
        base_rr = rr_cnt;
        press_key(4'hF, 3);
        chk("gr_pulse_cycles", rr_cnt - base_rr, 1);
        chk("gr_col", rr_col, 3'd3);
        chk("gr_pop", rr_pop, 1'b0);
        chk("gr_no_move", mv_cnt - base_mv, 0);
        chk("gr_btn", bus.keypadButton, 4'hF);
        chk("never_both", both_cnt, 0);

        // Asynchronous reset mid-scan
        pressed = 16'h0;
        pressed[key_idx(4'hB)] = 1'b1;
        wait_scans(4);
        chk("ar_pre_col", bus.col, 3'd4);
        chk("ar_pre_held", bus.key_held, 1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_kp_col", bus.kp_col_out, 4'b1110);
        chk("ar_col", bus.col, 3'd3);
        chk("ar_held", bus.key_held, 1'b0);
        chk("ar_btn", bus.keypadButton, 4'h0);
        chk("ar_pop_pulses", {bus.pop, bus.move_stb, bus.reset_req}, 3'b000);
        pressed = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
